// File: rtl/muldiv_unit.sv
// Iterative signed multiply / restoring divide unit owning the HI/LO registers.
// Optional MULDIV_UNSIGNED_EN enables the MULTU/DIVU opcodes (signs forced positive).
module muldiv_unit #(
  parameter logic [5:0] MULT_OP  = 6'b000010,
  parameter logic [5:0] DIV_OP   = 6'b000011,
  parameter logic [5:0] MFHI_OP  = 6'b000100,
  parameter logic [5:0] MFLO_OP  = 6'b000101,
  parameter logic [5:0] MULTU_OP = 6'b000110,
  parameter logic [5:0] DIVU_OP  = 6'b000111
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [5:0]  aluop,
  input  logic [31:0] rA,
  input  logic [31:0] rB,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data,
  output logic        done
);

`ifdef MULDIV_UNSIGNED_EN
  localparam logic UNSIGNED_EN = 1'b1;
`else
  localparam logic UNSIGNED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state_reg, state_next;
  logic [63:0] acc_reg, acc_next;
  logic [31:0] opb_reg, opb_next;
  logic [4:0]  count_reg, count_next;
  logic        sign_q_reg, sign_q_next;
  logic        sign_r_reg, sign_r_next;
  logic        is_div_reg, is_div_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        done_reg, done_next;

  logic        op_mult, op_div, op_unsigned, op_mf;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ok;
  logic [31:0] div_rem;
  logic [63:0] prod_fix;

  // Case-equality keeps X/Z opcodes from matching anything.
  always_comb begin
    op_mult     = (aluop === MULT_OP) || (UNSIGNED_EN && (aluop === MULTU_OP));
    op_div      = (aluop === DIV_OP)  || (UNSIGNED_EN && (aluop === DIVU_OP));
    op_unsigned = UNSIGNED_EN && ((aluop === MULTU_OP) || (aluop === DIVU_OP));
    op_mf       = (aluop === MFHI_OP) || (aluop === MFLO_OP);
  end

  assign busy    = (state_reg != IDLE);
  assign stall   = busy & (op_mult | op_div | op_mf);
  assign hi      = hi_reg;
  assign lo      = lo_reg;
  assign done    = done_reg;
  assign mf_data = (aluop === MFHI_OP) ? hi_reg : lo_reg;

  always_comb begin
    abs_a = (!op_unsigned && rA[31]) ? (~rA + 32'd1) : rA;
    abs_b = (!op_unsigned && rB[31]) ? (~rB + 32'd1) : rB;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  // Divide:   acc = {remainder, dividend/quotient bits}, shifted left each step.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opb_reg} : 33'd0);
    div_shift = {acc_reg[63:32], acc_reg[31]};
    div_ok    = (div_shift >= {1'b0, opb_reg});
    div_rem   = div_ok ? (div_shift[31:0] - opb_reg) : div_shift[31:0];
    prod_fix  = sign_q_reg ? (~acc_reg + 64'd1) : acc_reg;
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    opb_next    = opb_reg;
    count_next  = count_reg;
    sign_q_next = sign_q_reg;
    sign_r_next = sign_r_reg;
    is_div_next = is_div_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (op_mult) begin
          acc_next    = {32'd0, abs_b};
          opb_next    = abs_a;
          sign_q_next = !op_unsigned && (rA[31] ^ rB[31]);
          sign_r_next = 1'b0;
          is_div_next = 1'b0;
          count_next  = 5'd0;
          state_next  = MUL;
        end else if (op_div) begin
          count_next  = 5'd0;
          is_div_next = 1'b1;
          if (rB == 32'd0) begin
            // Divide by zero: preload the fixed result and skip iteration.
            acc_next    = {rA, 32'hFFFF_FFFF};
            opb_next    = 32'd0;
            sign_q_next = 1'b0;
            sign_r_next = 1'b0;
            state_next  = FIX;
          end else begin
            acc_next    = {32'd0, abs_a};
            opb_next    = abs_b;
            sign_q_next = !op_unsigned && (rA[31] ^ rB[31]);
            sign_r_next = !op_unsigned && rA[31];
            state_next  = DIV;
          end
        end
      end
      MUL: begin
        acc_next   = {mul_sum, acc_reg[31:1]};
        count_next = count_reg + 5'd1;
        if (count_reg == 5'd31) state_next = FIX;
      end
      DIV: begin
        acc_next   = {div_rem, acc_reg[30:0], div_ok};
        count_next = count_reg + 5'd1;
        if (count_reg == 5'd31) state_next = FIX;
      end
      FIX: begin
        if (is_div_reg) begin
          lo_next = sign_q_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
          hi_next = sign_r_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
        end else begin
          hi_next = prod_fix[63:32];
          lo_next = prod_fix[31:0];
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      acc_reg    <= 64'd0;
      opb_reg    <= 32'd0;
      count_reg  <= 5'd0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      is_div_reg <= 1'b0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      opb_reg    <= opb_next;
      count_reg  <= count_next;
      sign_q_reg <= sign_q_next;
      sign_r_reg <= sign_r_next;
      is_div_reg <= is_div_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      done_reg   <= done_next;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes model results, monitor checks on done.
module tb_muldiv_unit;

  localparam logic [5:0] MULT_OP  = 6'b000010;
  localparam logic [5:0] DIV_OP   = 6'b000011;
  localparam logic [5:0] MFHI_OP  = 6'b000100;
  localparam logic [5:0] MFLO_OP  = 6'b000101;
  localparam logic [5:0] MULTU_OP = 6'b000110;
  localparam logic [5:0] DIVU_OP  = 6'b000111;
  localparam logic [5:0] NOP_OP   = 6'b100001;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  aluop = NOP_OP;
  logic [31:0] rA = 32'd0;
  logic [31:0] rB = 32'd0;
  logic        busy, stall, done;
  logic [31:0] hi, lo, mf_data;

  int compared = 0;
  int mismatched = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  muldiv_unit dut (
    .clock(clock), .reset_n(reset_n), .aluop(aluop), .rA(rA), .rB(rB),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo), .mf_data(mf_data), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference: plain 64-bit arithmetic (truncating division, remainder takes dividend sign).
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    e.lat = 33;
    e.hi = 32'd0;
    e.lo = 32'd0;
    if (op == MULT_OP) begin
      p = sa * sb;
      {e.hi, e.lo} = p;
    end else if (op == MULTU_OP) begin
      up = ua * ub;
      {e.hi, e.lo} = up;
    end else if (b == 32'd0) begin
      e.lat = 1;
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
    end else if (op == DIV_OP) begin
      q = sa / sb;
      r = sa % sb;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end else begin
      up = ua / ub;
      e.lo = up[31:0];
      up = ua % ub;
      e.hi = up[31:0];
    end
    return e;
  endfunction

  // Called just after a negedge; returns shortly after the negedge following acceptance.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int  waited;
    bit  accepted;
    waited = 0;
    accepted = 0;
    aluop = op;
    rA = a;
    rB = b;
    while (!accepted && waited < 200) begin
      #1;
      if (stall === 1'b0) begin
        exp_q.push_back(model(op, a, b));
        @(posedge clock);
        accepted = 1;
      end else begin
        @(negedge clock);
        waited++;
      end
    end
    if (!accepted) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: op %h never accepted within 200 cycles", op);
    end
    @(negedge clock);
    aluop = NOP_OP;
    rA = $urandom;
    rB = $urandom;
    #1;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("nop_no_stall", {63'd0, stall}, 64'd0);
  endtask

  // Monitor: counts busy cycles per op and checks HI/LO on every done pulse.
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: hi %h lo %h with empty scoreboard", hi, lo);
        end else begin
          e = exp_q.pop_front();
          chk("hi", {32'd0, hi}, {32'd0, e.hi});
          chk("lo", {32'd0, lo}, {32'd0, e.lo});
          chk("busy_cycles", 64'(busy_cnt), 64'(e.lat));
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    int n;
    int sel;
    logic [5:0]  op;
    logic [31:0] a, b;

    repeat (2) @(negedge clock);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    issue(MULT_OP, 32'd7, 32'hFFFF_FFFD);
    issue(DIV_OP, 32'hFFFF_FFF9, 32'd2);
    issue(DIV_OP, 32'h1234_5678, 32'd0);
    issue(DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);

    // MFLO waiting on a MULT: stalled for all remaining busy cycles, then reads the product.
    issue(MULT_OP, 32'd3, 32'd5);
    aluop = MFLO_OP;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!busy) break;
      chk("mflo_stall", {63'd0, stall}, 64'd1);
      n++;
      @(negedge clock);
    end
    chk("mflo_stall_cycles", 64'(n), 64'd33);
    chk("mflo_released", {63'd0, stall}, 64'd0);
    chk("mflo_data", {32'd0, mf_data}, 64'd15);
    aluop = MFHI_OP;
    #1;
    chk("mfhi_data", {32'd0, mf_data}, 64'd0);
    @(negedge clock);

    // Unused codes, including X, must not start anything.
    aluop = 6'bxxxxxx;
    repeat (2) @(negedge clock);
    aluop = NOP_OP;
    repeat (2) @(negedge clock);
    chk("ignored_ops_idle", {63'd0, busy}, 64'd0);

`ifdef MULDIV_UNSIGNED_EN
    issue(MULTU_OP, 32'hFFFF_FFFF, 32'd2);
    issue(DIVU_OP, 32'hFFFF_FFFF, 32'd0);
    issue(DIVU_OP, 32'hFFFF_FFF0, 32'd7);
`else
    aluop = MULTU_OP;
    #1;
    chk("multu_no_stall", {63'd0, stall}, 64'd0);
    repeat (3) @(negedge clock);
    chk("multu_ignored", {63'd0, busy}, 64'd0);
    aluop = DIVU_OP;
    repeat (3) @(negedge clock);
    chk("divu_ignored", {63'd0, busy}, 64'd0);
    aluop = NOP_OP;
`endif

    // Async reset in the middle of a MULT abandons it and clears HI/LO.
    issue(MULT_OP, 32'h0001_2345, 32'h0000_6789);
    repeat (9) @(negedge clock);
    #2;
    reset_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("midop_reset_busy", {63'd0, busy}, 64'd0);
    chk("midop_reset_hi", {32'd0, hi}, 64'd0);
    chk("midop_reset_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Randomized back-to-back traffic; each new op is held by stall until the unit is idle.
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 100) - 50; b = $urandom_range(1, 9); end
      else if (sel == 3) b = {28'd0, 4'($urandom_range(1, 15))};
`ifdef MULDIV_UNSIGNED_EN
      case ($urandom_range(0, 3))
        0: op = MULT_OP;
        1: op = DIV_OP;
        2: op = MULTU_OP;
        default: op = DIVU_OP;
      endcase
`else
      op = ($urandom_range(0, 1) == 0) ? MULT_OP : DIV_OP;
`endif
      issue(op, a, b);
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit beside the execute stage. Owns the architectural HI/LO registers for MULT, DIV, MFHI and MFLO.
- Takes decoded aluop and forwarded rA/rB operands from D/X.
- Runs a multi-cycle shift-add multiply or restoring divide.
- Raises a stall request to hold F/D and D/X while a dependent instruction waits.
- Supplies HI/LO data to the execute result mux for MFHI/MFLO.

Parameters:
MULT_OP, 6'b000010, aluop code for signed multiply
DIV_OP, 6'b000011, aluop code for signed divide
MFHI_OP, 6'b000100, aluop code for move-from-HI
MFLO_OP, 6'b000101, aluop code for move-from-LO
MULTU_OP, 6'b000110, unsigned multiply code (used only with optional feature)
DIVU_OP, 6'b000111, unsigned divide code (used only with optional feature)

Ports:
clock  in  1  single clock; all state updates on posedge
reset_n  in  1  asynchronous, active-low reset
aluop  in  6  operation code from D/X (aluop_DX)
rA  in  32  operand rs (post-bypass); multiplicand / dividend
rB  in  32  operand rt (post-bypass); multiplier / divisor
busy  out  1  operation in flight
stall  out  1  request to freeze F/D and D/X and bubble X/M
hi  out  32  architectural HI
lo  out  32  architectural LO
mf_data  out  32  HI if aluop==MFHI_OP, else LO (combinational)
done  out  1  one-cycle pulse on the edge HI/LO are written

Behaviour:
- Reset (async, reset_n low): state=IDLE, hi=0, lo=0, busy=0, done=0, count=0, internal accumulators=0. A reset mid-operation abandons the op and leaves HI/LO at 0.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - On a posedge with aluop==MULT_OP, load |rA|, |rB|, and the result sign = rA[31]^rB[31]; go to MUL.
  - With aluop==DIV_OP, also latch the remainder sign = rA[31]; go to DIV.
  - count=0 on entry to either state.
- MUL: one shift-add step per cycle into a 64-bit accumulator; count increments. After the step with count==31, go to FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). After count==31, go to FIX.
- FIX: apply two's-complement negation per latched signs.
  - MULT: {hi,lo} = signed 64-bit product.
  - DIV: lo = quotient; hi = remainder, which takes the dividend's sign.
  - Write hi/lo, pulse done, return to IDLE.
- Latency: accept edge E; hi/lo visible after edge E+33. busy is high for exactly 33 cycles (state != IDLE).
- HI/LO hold their old values for the whole operation; they update only in FIX.
- Divide by zero, detected at accept: skip iteration and go straight to FIX (busy for 1 cycle). Result lo=32'hFFFFFFFF, hi=rA.
- Signed overflow (rA=32'h80000000, rB=32'hFFFFFFFF): normal path; result lo=32'h80000000, hi=0.
- stall = busy & (aluop is MULT_OP, DIV_OP, MFHI_OP or MFLO_OP).
  - A new MULT/DIV is never accepted while busy; it is held by the stall and accepted on the first IDLE edge.
  - stall=0 in the FIX cycle's successor. MFHI/MFLO issued on that cycle read the new HI/LO through mf_data.
- Any aluop outside the active codes is ignored in IDLE, including NOP 6'b100001 and X/Z values (compare with ===).
- Operand capture happens only at the accept edge; later changes to rA/rB do not affect the operation.

Optional Feature:
MULDIV_UNSIGNED_EN
- Defined: MULTU_OP and DIVU_OP are accepted like MULT/DIV but skip abs/negate (signs forced positive). They are included in the stall decode.
- Divide by zero for DIVU gives the same lo=FFFFFFFF, hi=rA.
- Undefined: these codes are ignored exactly like any unused code, with no stall and no state change.

Test Plan:
- MULT rA=7, rB=32'hFFFFFFFD → busy 33 cycles, done pulse, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- DIV rA=32'hFFFFFFF9 (−7), rB=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF after 33 cycles.
- DIV rB=0, rA=32'h12345678 → busy 1 cycle, lo=32'hFFFFFFFF, hi=32'h12345678.
- DIV 32'h80000000 / 32'hFFFFFFFF → lo=32'h80000000, hi=0, no X.
- MULT 3×5, then MFLO held on aluop next cycle → stall=1 for the remaining busy cycles; first cycle after, stall=0 and mf_data=15. A second MULT held during busy starts only after the first completes.
- Reset pulse (reset_n=0 for 2 cycles) at iteration 10 of MULT → state IDLE, hi=lo=0, busy=0 immediately (async). With MULDIV_UNSIGNED_EN, MULTU 32'hFFFFFFFF×2 → hi=1, lo=32'hFFFFFFFE.
